spi_aes_responder: RTL and testbench

SPI responder (slave) front end for the AES cores. It sits on the far end of the byte-oriented SPI link driven by `master`. It deserialises an upload frame of 16 text bytes, one key-size byte and 16/24/32 key bytes, then presents text and key to the attached AES core in parallel. It waits for the core's 128-bit result and serialises it back as 16 bytes. It pulses `done` after every byte, which the host uses to pace transfers.

---
 rtl/aes_spi_pkg.sv | 21 ++
 rtl/spi_byte_shifter.sv | 84 ++++++++
 rtl/spi_aes_responder.sv | 184 ++++++++++++++++++
 tb/tb_spi_aes_responder.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_spi_pkg.sv
// Shared encodings and constants for the SPI front end of the AES cores.
package aes_spi_pkg;

  typedef enum logic [2:0] {
    RX_TEXT   = 3'd0,
    RX_SIZE   = 3'd1,
    RX_KEY    = 3'd2,
    WAIT_CORE = 3'd3,
    TX_RESULT = 3'd4
  } state_t;

  localparam logic [7:0] SIZE_128 = 8'd16;
  localparam logic [7:0] SIZE_192 = 8'd24;
  localparam logic [7:0] SIZE_256 = 8'd32;
  localparam int TEXT_BYTES = 16;

  function automatic logic key_size_ok(input logic [7:0] size_byte);
    return (size_byte == SIZE_128) || (size_byte == SIZE_192) || (size_byte == SIZE_256);
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 SPI bit engine: synchronisers, edge detect, bit counter, rx and tx shifters.
module spi_byte_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs,
  input  logic       mosi,
  input  logic       load,
  input  logic [7:0] load_byte,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       miso
);

  logic [1:0] sclk_sync;
  logic [1:0] cs_sync;
  logic [1:0] mosi_sync;
  logic       sclk_d;
  logic       cs_d;
  logic [2:0] bit_cnt;
  logic [7:0] rx_sr;
  logic [7:0] tx_sr;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_active;

  assign sclk_s    = sclk_sync[1];
  assign cs_s      = cs_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  // One extra cycle of cs history lets an edge coinciding with cs rising still count.
  assign cs_active = ~(cs_s & cs_d);

  assign byte_done = sclk_rise & cs_active & (bit_cnt == 3'd7);
  assign rx_byte   = {rx_sr[6:0], mosi_s};
  assign miso      = tx_sr[7];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      cs_sync   <= {cs_sync[0], cs};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt <= 3'd0;
      rx_sr   <= 8'h00;
    end else if (sclk_rise && cs_active) begin
      rx_sr   <= {rx_sr[6:0], mosi_s};
      bit_cnt <= bit_cnt + 3'd1;
    end else if (cs_s) begin
      bit_cnt <= 3'd0;
      rx_sr   <= 8'h00;
    end
  end

  // Falling edges only shift mid-byte, so the idle-return fall after bit 0
  // never eats the MSB of a freshly loaded byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_sr <= 8'h00;
    end else if (load) begin
      tx_sr <= load_byte;
    end else if (sclk_fall && !cs_s && (bit_cnt != 3'd0)) begin
      tx_sr <= {tx_sr[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/spi_aes_responder.sv
// SPI responder that collects text/key frames for an AES core and returns its result.
module spi_aes_responder
  import aes_spi_pkg::*;
#(
  parameter int TEXT_BYTES    = 16,
  parameter int MAX_KEY_BYTES = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cs,
  input  logic                         sclk,
  input  logic                         mosi,
  output logic                         miso,
  output logic                         done,
  output logic [8*TEXT_BYTES-1:0]      text_out,
  output logic [8*MAX_KEY_BYTES-1:0]   key_out,
  output logic [7:0]                   key_size,
  output logic                         frame_valid,
  input  logic [8*TEXT_BYTES-1:0]      result_in,
  input  logic                         result_valid,
  output logic                         tx_active,
  output logic                         err,
  output state_t                       state
);

  localparam int TW = 8 * TEXT_BYTES;
  localparam int KW = 8 * MAX_KEY_BYTES;

  logic          byte_done;
  logic [7:0]    rx_byte;
  logic [5:0]    byte_idx;
  logic [TW-1:0] tx_buf;

  state_t        state_n;
  logic [5:0]    idx_n;
  logic          done_n;
  logic          fv_n;
  logic          txa_n;
  logic          err_n;
  logic          cap_text;
  logic          cap_size;
  logic          cap_key;
  logic          cap_result;
  logic          adv_result;
  logic          load;
  logic [7:0]    load_byte;

  spi_byte_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .cs        (cs),
    .mosi      (mosi),
    .load      (load),
    .load_byte (load_byte),
    .byte_done (byte_done),
    .rx_byte   (rx_byte),
    .miso      (miso)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RX_TEXT;
    else        state <= state_n;
  end

  // result_valid is a single-cycle strobe; it is only consumed in WAIT_CORE and
  // there is no back-pressure towards the core.
  always_comb begin
    state_n    = state;
    idx_n      = byte_idx;
    done_n     = 1'b0;
    fv_n       = 1'b0;
    txa_n      = tx_active;
    err_n      = err;
    cap_text   = 1'b0;
    cap_size   = 1'b0;
    cap_key    = 1'b0;
    cap_result = 1'b0;
    adv_result = 1'b0;
    load       = 1'b0;
    load_byte  = 8'h00;
    case (state)
      RX_TEXT: begin
        if (byte_done) begin
          done_n   = 1'b1;
          cap_text = 1'b1;
          if (byte_idx == 6'd0) err_n = 1'b0;
          if (byte_idx == 6'(TEXT_BYTES - 1)) begin
            idx_n   = 6'd0;
            state_n = RX_SIZE;
          end else begin
            idx_n = byte_idx + 6'd1;
          end
        end
      end
      RX_SIZE: begin
        if (byte_done) begin
          done_n = 1'b1;
          idx_n  = 6'd0;
          if (key_size_ok(rx_byte)) begin
            cap_size = 1'b1;
            state_n  = RX_KEY;
          end else begin
            err_n   = 1'b1;
            state_n = RX_TEXT;
          end
        end
      end
      RX_KEY: begin
        if (byte_done) begin
          done_n  = 1'b1;
          cap_key = 1'b1;
          if ({2'b00, byte_idx} == key_size - 8'd1) begin
            fv_n    = 1'b1;
            idx_n   = 6'd0;
            state_n = WAIT_CORE;
          end else begin
            idx_n = byte_idx + 6'd1;
          end
        end
      end
      WAIT_CORE: begin
        if (result_valid) begin
          cap_result = 1'b1;
          load       = 1'b1;
          load_byte  = result_in[TW-1 -: 8];
          txa_n      = 1'b1;
          idx_n      = 6'd0;
          state_n    = TX_RESULT;
        end
      end
      TX_RESULT: begin
        if (byte_done) begin
          done_n = 1'b1;
          load   = 1'b1;
          if (byte_idx == 6'(TEXT_BYTES - 1)) begin
            load_byte = 8'h00;
            txa_n     = 1'b0;
            idx_n     = 6'd0;
            state_n   = RX_TEXT;
          end else begin
            load_byte  = tx_buf[TW-1 -: 8];
            adv_result = 1'b1;
            idx_n      = byte_idx + 6'd1;
          end
        end
      end
      default: begin
        state_n = RX_TEXT;
        idx_n   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx    <= 6'd0;
      done        <= 1'b0;
      frame_valid <= 1'b0;
      tx_active   <= 1'b0;
      err         <= 1'b0;
      text_out    <= '0;
      key_out     <= '0;
      key_size    <= 8'h00;
      tx_buf      <= '0;
    end else begin
      byte_idx    <= idx_n;
      done        <= done_n;
      frame_valid <= fv_n;
      tx_active   <= txa_n;
      err         <= err_n;
      if (cap_text) text_out <= {text_out[TW-9:0], rx_byte};
      if (cap_size) begin
        key_size <= rx_byte;
        key_out  <= '0;
      end
      if (cap_key) key_out <= {key_out[KW-9:0], rx_byte};
      // tx_buf holds the result bytes not yet handed to the shifter.
      if (cap_result)      tx_buf <= {result_in[TW-9:0], 8'h00};
      else if (adv_result) tx_buf <= {tx_buf[TW-9:0], 8'h00};
    end
  end

endmodule

// File: tb/tb_spi_aes_responder.sv
// Self-checking bench for spi_aes_responder driven as an SPI host with per-byte cs.
module tb_spi_aes_responder;
  import aes_spi_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cs = 1'b1;
  logic         sclk = 1'b0;
  logic         mosi = 1'b0;
  logic         miso;
  logic         done;
  logic [127:0] text_out;
  logic [255:0] key_out;
  logic [7:0]   key_size;
  logic         frame_valid;
  logic [127:0] result_in = '0;
  logic         result_valid = 1'b0;
  logic         tx_active;
  logic         err;
  state_t       state;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int fv_cnt = 0;
  logic [7:0] exp_q[$];

  localparam logic [127:0] TEXT = 128'h00112233445566778899aabbccddeeff;

  spi_aes_responder #(.TEXT_BYTES(16), .MAX_KEY_BYTES(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .cs           (cs),
    .sclk         (sclk),
    .mosi         (mosi),
    .miso         (miso),
    .done         (done),
    .text_out     (text_out),
    .key_out      (key_out),
    .key_size     (key_size),
    .frame_valid  (frame_valid),
    .result_in    (result_in),
    .result_valid (result_valid),
    .tx_active    (tx_active),
    .err          (err),
    .state        (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (frame_valid) begin
      fv_cnt++;
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("FAIL fv_with_done: done=%b required 1 while frame_valid", done);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    wait_clk(3);
    reset = 1'b1;
    wait_clk(2);
  endtask

  // ---------------- driver tasks ----------------
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    rx = 8'h00;
    cs = 1'b0;
    wait_clk(3);
    for (int b = 7; b >= 0; b--) begin
      mosi = tx[b];
      wait_clk(5);
      rx = {rx[6:0], miso};
      sclk = 1'b1;
      wait_clk(5);
      sclk = 1'b0;
    end
    wait_clk(2);
    cs = 1'b1;
    mosi = 1'b0;
    wait_clk(5);
  endtask

  task automatic send_byte(input logic [7:0] tx);
    logic [7:0] dummy;
    spi_byte(tx, dummy);
  endtask

  task automatic send_frame(input logic [127:0] text, input logic [7:0] size,
                            input logic [255:0] key, input int nkey);
    for (int i = 0; i < 16; i++) send_byte(text[127-8*i -: 8]);
    send_byte(size);
    for (int i = 0; i < nkey; i++) send_byte(key[8*nkey-1-8*i -: 8]);
  endtask

  function automatic logic [255:0] make_key(input int n);
    logic [255:0] k;
    k = '0;
    for (int i = 0; i < n; i++) k = {k[247:0], 8'(i)};
    return k;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if ({miso, done, frame_valid, tx_active, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000", {miso, done, frame_valid, tx_active, err});
    end
    checks++;
    if (text_out !== '0 || key_out !== '0 || key_size !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: text=%h key=%h size=%h required zero", text_out, key_out, key_size);
    end
    checks++;
    if (state !== RX_TEXT) begin
      errors++;
      $display("FAIL reset_state: got %0d required %0d", state, RX_TEXT);
    end
    result_in = {$urandom, $urandom, $urandom, $urandom};
    result_valid = 1'b1;
    wait_clk(1);
    result_valid = 1'b0;
    wait_clk(2);
    checks++;
    if (tx_active !== 1'b0 || state !== RX_TEXT) begin
      errors++;
      $display("FAIL rv_outside_wait: tx_active=%b state=%0d required 0/%0d", tx_active, state, RX_TEXT);
    end
  endtask

  task automatic test_aes256();
    int d0, f0;
    logic [255:0] k;
    d0 = done_cnt; f0 = fv_cnt;
    k = make_key(32);
    send_frame(TEXT, 8'h20, k, 32);
    checks++;
    if (done_cnt - d0 != 49) begin
      errors++;
      $display("FAIL aes256_done: got %0d required 49", done_cnt - d0);
    end
    checks++;
    if (fv_cnt - f0 != 1) begin
      errors++;
      $display("FAIL aes256_fv: got %0d required 1", fv_cnt - f0);
    end
    checks++;
    if (key_out !== k || key_size !== 8'd32) begin
      errors++;
      $display("FAIL aes256_key: key=%h size=%0d required %h/32", key_out, key_size, k);
    end
    checks++;
    if (text_out !== TEXT || state !== WAIT_CORE) begin
      errors++;
      $display("FAIL aes256_text: text=%h state=%0d required %h/%0d", text_out, state, TEXT, WAIT_CORE);
    end
  endtask

  task automatic test_result(input logic [127:0] r);
    int d0;
    logic [7:0] rx, exp_b;
    d0 = done_cnt;
    send_byte(8'h55);
    checks++;
    if (done_cnt != d0 || state !== WAIT_CORE) begin
      errors++;
      $display("FAIL wait_ignore: done delta %0d state %0d required 0/%0d", done_cnt - d0, state, WAIT_CORE);
    end
    for (int i = 0; i < 16; i++) exp_q.push_back(r[127-8*i -: 8]);
    result_in = r;
    result_valid = 1'b1;
    wait_clk(1);
    result_valid = 1'b0;
    result_in = {$urandom, $urandom, $urandom, $urandom};
    checks++;
    if (tx_active !== 1'b1) begin
      errors++;
      $display("FAIL tx_active_rise: got %b required 1", tx_active);
    end
    wait_clk(2);
    for (int i = 0; i < 16; i++) begin
      spi_byte(8'($urandom_range(0, 255)), rx);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_byte%0d: got %h, scoreboard empty", i, rx);
      end else begin
        exp_b = exp_q.pop_front();
        if (rx !== exp_b) begin
          errors++;
          $display("FAIL tx_byte%0d: got %h required %h", i, rx, exp_b);
        end
      end
    end
    checks++;
    if (done_cnt - d0 != 16) begin
      errors++;
      $display("FAIL tx_done: got %0d required 16", done_cnt - d0);
    end
    checks++;
    if (tx_active !== 1'b0 || miso !== 1'b0 || state !== RX_TEXT) begin
      errors++;
      $display("FAIL tx_end: tx_active=%b miso=%b state=%0d required 0/0/%0d", tx_active, miso, state, RX_TEXT);
    end
  endtask

  task automatic test_aes128();
    int d0, f0;
    logic [255:0] k;
    d0 = done_cnt; f0 = fv_cnt;
    k = make_key(16);
    send_frame(TEXT, 8'h10, k, 16);
    checks++;
    if (done_cnt - d0 != 33 || fv_cnt - f0 != 1) begin
      errors++;
      $display("FAIL aes128_counts: done %0d fv %0d required 33/1", done_cnt - d0, fv_cnt - f0);
    end
    checks++;
    if (key_out[127:0] !== k[127:0] || key_out[255:128] !== 128'h0) begin
      errors++;
      $display("FAIL aes128_key: got %h required %h", key_out, k);
    end
    checks++;
    if (key_size !== 8'd16) begin
      errors++;
      $display("FAIL aes128_size: got %0d required 16", key_size);
    end
  endtask

  task automatic test_bad_size();
    int d0, f0;
    d0 = done_cnt; f0 = fv_cnt;
    send_frame(TEXT, 8'h11, '0, 0);
    checks++;
    if (err !== 1'b1 || state !== RX_TEXT) begin
      errors++;
      $display("FAIL bad_size_err: err=%b state=%0d required 1/%0d", err, state, RX_TEXT);
    end
    checks++;
    if (fv_cnt != f0 || done_cnt - d0 != 17) begin
      errors++;
      $display("FAIL bad_size_counts: fv %0d done %0d required 0/17", fv_cnt - f0, done_cnt - d0);
    end
    send_byte(8'hA5);
    checks++;
    if (err !== 1'b0 || text_out[7:0] !== 8'hA5) begin
      errors++;
      $display("FAIL bad_size_recover: err=%b text_lsb=%h required 0/a5", err, text_out[7:0]);
    end
  endtask

  task automatic test_partial();
    int d0, f0;
    logic [127:0] exp_text;
    logic [255:0] k;
    logic [7:0] b;
    d0 = done_cnt;
    cs = 1'b0;
    wait_clk(3);
    for (int i = 0; i < 5; i++) begin
      mosi = 1'($urandom_range(0, 1));
      wait_clk(5);
      sclk = 1'b1;
      wait_clk(5);
      sclk = 1'b0;
    end
    wait_clk(2);
    cs = 1'b1;
    wait_clk(6);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL partial_no_done: done delta %0d required 0", done_cnt - d0);
    end
    send_byte(8'h3C);
    checks++;
    if (text_out[15:0] !== 16'hA53C) begin
      errors++;
      $display("FAIL partial_index: got %h required a53c", text_out[15:0]);
    end
    exp_text = 128'hA53C;
    for (int i = 0; i < 14; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_text = {exp_text[119:0], b};
      send_byte(b);
    end
    f0 = fv_cnt;
    send_byte(8'h18);
    k = '0;
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom_range(0, 255));
      k = {k[247:0], b};
      send_byte(b);
    end
    checks++;
    if (text_out !== exp_text || fv_cnt - f0 != 1) begin
      errors++;
      $display("FAIL aes192_text: text=%h fv %0d required %h/1", text_out, fv_cnt - f0, exp_text);
    end
    checks++;
    if (key_out !== k || key_size !== 8'd24) begin
      errors++;
      $display("FAIL aes192_key: key=%h size=%0d required %h/24", key_out, key_size, k);
    end
  endtask

  task automatic test_reset_mid();
    int f0;
    logic [255:0] k;
    logic [127:0] t2;
    send_frame(TEXT, 8'h20, make_key(32), 5);
    checks++;
    if (state !== RX_KEY) begin
      errors++;
      $display("FAIL mid_state: got %0d required %0d", state, RX_KEY);
    end
    reset = 1'b0;
    wait_clk(1);
    checks++;
    if ({miso, done, frame_valid, tx_active, err} !== 5'b0 || text_out !== '0 ||
        key_out !== '0 || key_size !== 8'h00 || state !== RX_TEXT) begin
      errors++;
      $display("FAIL mid_reset: flags=%b text=%h key=%h size=%h state=%0d required all zero/%0d",
               {miso, done, frame_valid, tx_active, err}, text_out, key_out, key_size, state, RX_TEXT);
    end
    reset = 1'b1;
    wait_clk(2);
    f0 = fv_cnt;
    t2 = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send_frame(t2, 8'h20, k, 32);
    checks++;
    if (fv_cnt - f0 != 1 || text_out !== t2 || key_out !== k) begin
      errors++;
      $display("FAIL mid_fresh: fv %0d text=%h key=%h required 1/%h/%h", fv_cnt - f0, text_out, key_out, t2, k);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_aes256();
    test_result(128'h8ea2b7ca516745bfeafc49904b496089);
    test_aes128();
    test_result({$urandom, $urandom, $urandom, $urandom});
    test_bad_size();
    test_partial();
    test_result({$urandom, $urandom, $urandom, $urandom});
    test_reset_mid();
    test_result({$urandom, $urandom, $urandom, $urandom});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
